// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Handles load-use hazards, branch/jump flushes, data-memory wait freezes
// with a timeout trap, and saturating stall/flush performance counters.
module pipeline_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LoadE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             BubbleW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    // Wait counter reaches at most MEM_TIMEOUT-1 (<= 254), so 8 bits suffice.
    localparam logic [7:0]       WaitLast = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic freeze;
    logic branch_flush;
    logic lu_stall;

    // x0 is never a real producer, so it cannot create a hazard.
    assign lu = LoadE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

    // Next-state logic and Mealy control decode.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        freeze       = 1'b0;
        branch_flush = 1'b0;
        lu_stall     = 1'b0;
        case (state_q)
            StRun: begin
                // A pending memory access wins; EX is held so branch/lu re-present later.
                if (MemReqM && !MemReadyM) begin
                    freeze     = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else if (PCSrcE) begin
                    branch_flush = 1'b1;
                end else if (lu) begin
                    lu_stall = 1'b1;
                end
            end
            StMemWait: begin
                if (MemReadyM) begin
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                    if (PCSrcE) begin
                        branch_flush = 1'b1;
                    end else if (lu) begin
                        lu_stall = 1'b1;
                    end
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WaitLast) begin
                        state_d   = StError;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            StError: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
        // Reset forces the pipeline controls quiet in the same cycle.
        if (rst) begin
            freeze       = 1'b0;
            branch_flush = 1'b0;
            lu_stall     = 1'b0;
        end
    end

    // Output decode from the control classification.
    always_comb begin
        StallF   = freeze | lu_stall;
        StallD   = freeze | lu_stall;
        StallE   = freeze;
        StallM   = freeze;
        BubbleW  = freeze;
        FlushD   = branch_flush;
        FlushE   = branch_flush | lu_stall;
        MemErr   = mem_err_q;
        StallCnt = stall_cnt_q;
        FlushCnt = flush_cnt_q;
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_flush && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Detects load-use hazards that forwarding cannot cover.
- Applies branch/jump flushes.
- Freezes the whole pipeline while data memory is not ready, with a timeout watchdog.
- Keeps saturating stall and flush performance counters.
- Sits beside the forwarding unit; its outputs drive the enables and clears of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready cycles of one memory request before the error trap (legal range 2..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
LoadE  in  1  instruction in EX is a load
RD_E  in  5  destination register of the EX instruction
RS1_D  in  5  rs1 of the decode instruction
RS2_D  in  5  rs2 of the decode instruction
PCSrcE  in  1  branch taken or jump resolved in EX
MemReqM  in  1  MEM-stage instruction accesses data memory
MemReadyM  in  1  data memory completes the access this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
BubbleW  out  1  load a bubble into MEM/WB
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
MemErr  out  1  sticky memory-timeout error
StallCnt  out  CNT_W  cycles with StallF=1
FlushCnt  out  CNT_W  branch flush events

Behaviour:
States and timing:
- FSM states: RUN, MEM_WAIT, ERROR.
- Outputs are Mealy: a function of state and the current inputs, with no added latency.
- Reset state: RUN, wait counter 0, MemErr=0, StallCnt=0, FlushCnt=0.
- Reset takes priority over every event. It also aborts MEM_WAIT/ERROR at the next edge.
- While rst=1, all stall/flush/bubble outputs are 0.

Load-use hazard:
- lu = LoadE & (RD_E!=0) & (RD_E==RS1_D | RD_E==RS2_D).

RUN state, by priority (highest first):
1. MemReqM & !MemReadyM:
   - StallF=StallD=StallE=StallM=BubbleW=1, FlushD=FlushE=0.
   - Next state MEM_WAIT, wait counter := 1.
   - PCSrcE and lu are ignored this cycle; they re-present after release because EX is held.
2. PCSrcE:
   - FlushD=FlushE=1, all stalls 0.
   - FlushCnt increments.
   - A simultaneous lu is discarded, since the decode instruction is flushed.
3. lu:
   - StallF=StallD=1, FlushE=1, others 0.
   - Exactly one cycle; the next cycle the load sits in MEM and forwarding covers it.
4. Otherwise all outputs are 0.

MEM_WAIT state:
- MemReadyM=1: all stalls 0 this cycle, and RUN priorities 2-3 evaluate normally this cycle. Next state RUN, counter := 0.
- MemReadyM=0: the full freeze of RUN item 1 is held.
  - If counter == MEM_TIMEOUT-1: next state ERROR, MemErr := 1.
  - Else counter increments.
- ERROR is therefore entered after exactly MEM_TIMEOUT consecutive not-ready cycles.

ERROR state:
- Full freeze: StallF/D/E/M=1, BubbleW=1.
- MemErr=1.
- Held until rst.
- All other inputs are ignored.

Counters:
- StallCnt increments every cycle StallF=1, including ERROR.
- FlushCnt increments once per cycle with FlushD=1 caused by PCSrcE. The lu-only FlushE does not count.
- Both counters saturate at all-ones and do not wrap.

Register-zero rule:
- RD_E=0 never causes a load-use stall.

Test Plan:
1. Reset → all outputs 0, both counters 0, state RUN.
2. Load-use: LoadE=1, RD_E=5, RS2_D=5 for 1 cycle → StallF=StallD=FlushE=1 for exactly that cycle, StallCnt=1. Repeat with RD_E=0 → no stall.
3. Branch and load-use together: PCSrcE=1 with a load-use match → FlushD=FlushE=1, StallF=0, FlushCnt=1, StallCnt unchanged.
4. Memory wait: MemReqM=1, MemReadyM low 3 cycles then high → StallF/D/E/M and BubbleW high for 3 cycles, 0 on the ready cycle, StallCnt=3, state returns to RUN.
5. Timeout with MEM_TIMEOUT=4: MemReqM=1, MemReadyM held low → MemErr rises after the 4th low cycle and stays 1 even after MemReadyM=1. rst for 1 cycle clears it.
6. Saturation with CNT_W=4: 20 consecutive load-use cycles → StallCnt holds at 15 and does not wrap. Reset asserted mid-MEM_WAIT → RUN next cycle with outputs 0.
